// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one stall-handshake memory between fetch (p0) and load/store (p1).
// Latency: grant edge + memory time + one RESP cycle; a requester stays stalled until its RESP cycle.
module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 7
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic [DATA_W-1:0] p0_rdata,
  output logic              p0_stall,

  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              p1_stall,

  output logic              mem_cs,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout,
  input  logic              mem_stall,

  output logic              err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic [1:0]        state_q, state_d;
  logic              grant_q, grant_d;
  logic              last_grant_q, last_grant_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              mem_cs_q, mem_cs_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_din_q, mem_din_d;
  logic [DATA_W-1:0] p0_rdata_q, p0_rdata_d;
  logic [DATA_W-1:0] p1_rdata_q, p1_rdata_d;
  logic              err_q, err_d;

  logic              win;
  logic              done;

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    mem_cs_d     = mem_cs_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_din_d    = mem_din_q;
    p0_rdata_d   = p0_rdata_q;
    p1_rdata_d   = p1_rdata_q;
    err_d        = 1'b0;

    // On a tie the port that did not win last time gets the memory.
    win  = (p0_req & p1_req) ? ~last_grant_q : p1_req;
    done = mem_cs_q & ~mem_stall;

    case (state_q)
      S_IDLE: begin
        if (p0_req | p1_req) begin
          grant_d      = win;
          last_grant_d = win;
          cnt_d        = '0;
          mem_cs_d     = 1'b1;
          mem_we_d     = win ? p1_we    : p0_we;
          mem_addr_d   = win ? p1_addr  : p0_addr;
          mem_din_d    = win ? p1_wdata : p0_wdata;
          state_d      = S_BUSY;
        end
      end
      S_BUSY: begin
        if (done) begin
          if (!mem_we_q) begin
            if (grant_q) p1_rdata_d = mem_dout;
            else         p0_rdata_d = mem_dout;
          end
          mem_cs_d = 1'b0;
          mem_we_d = 1'b0;
          state_d  = S_RESP;
        end else if (cnt_q >= CNT_LAST) begin
          // Watchdog abort: release the memory and answer the requester without data.
          mem_cs_d = 1'b0;
          mem_we_d = 1'b0;
          err_d    = 1'b1;
          state_d  = S_RESP;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d  = S_IDLE;
        mem_cs_d = 1'b0;
        mem_we_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      cnt_q        <= '0;
      mem_cs_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_din_q    <= '0;
      p0_rdata_q   <= '0;
      p1_rdata_q   <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      mem_cs_q     <= mem_cs_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_din_q    <= mem_din_d;
      p0_rdata_q   <= p0_rdata_d;
      p1_rdata_q   <= p1_rdata_d;
      err_q        <= err_d;
    end
  end

  assign mem_cs   = mem_cs_q;
  assign mem_we   = mem_we_q;
  assign mem_addr = mem_addr_q;
  assign mem_din  = mem_din_q;
  assign p0_rdata = p0_rdata_q;
  assign p1_rdata = p1_rdata_q;
  assign err      = err_q;

  // Stall is released only in the granted port's RESP cycle, so the pipeline advances exactly once.
  assign p0_stall = p0_req & ~((state_q == S_RESP) & ~grant_q);
  assign p1_stall = p1_req & ~((state_q == S_RESP) &  grant_q);

endmodule
